// File: rtl/sqrt_arbiter.sv
// rtl/sqrt_arbiter.sv - round-robin arbiter sharing one sqrt unit among NREQ requesters
// Optional watchdog on the WAIT states: define SQRT_ARB_TIMEOUT_EN.
module sqrt_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NREQ-1:0]      req_i,
    input  logic [17*NREQ-1:0]   x_bi,
    output logic [NREQ-1:0]      gnt_o,
    output logic [NREQ-1:0]      rsp_valid_o,
    output logic [7:0]           y_bo,
    output logic                 err_o,
    output logic                 busy_o,
    output logic                 sq_start_o,
    output logic [16:0]          sq_x_bo,
    input  logic                 sq_busy_i,
    input  logic [7:0]           sq_y_bi
);

    localparam int WW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        RESP
    } state_e;

    state_e        state_q, state_d;
    logic [WW-1:0] w_q, w_d;
    logic [WW-1:0] last_q, last_d;
    logic [16:0]   x_q, x_d;
    logic [7:0]    y_q, y_d;

    logic          win_found;
    logic [WW-1:0] win_idx;
    logic [WW-1:0] cand_idx;
    int unsigned   cand;
    logic          timeout_taken;

    // Round-robin search starts one past the last served requester.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_q;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand     = (int'(last_q) + i) % NREQ;
            cand_idx = WW'(cand);
            if (!win_found && req_i[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        last_d  = last_q;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    w_d     = win_idx;
                    x_d     = x_bi[17*win_idx +: 17];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (sq_busy_i) begin
                    state_d = WAIT_DONE;
                end else if (timeout_taken) begin
                    y_d     = 8'd0;
                    state_d = RESP;
                end
            end
            WAIT_DONE: begin
                if (!sq_busy_i) begin
                    y_d     = sq_y_bi;
                    state_d = RESP;
                end else if (timeout_taken) begin
                    y_d     = 8'd0;
                    state_d = RESP;
                end
            end
            RESP: begin
                last_d  = w_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            w_q     <= '0;
            last_q  <= WW'(NREQ - 1);
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            last_q  <= last_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

`ifdef SQRT_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wdog_q, wdog_d;
    logic          err_q, err_d;
    logic          in_wait;
    logic          timeout_hit;

    assign in_wait     = (state_q == WAIT_BUSY) || (state_q == WAIT_DONE);
    assign timeout_hit = in_wait && (wdog_q == CW'(TIMEOUT - 1));
    // The watchdog only wins when the normal exit condition of the state is absent.
    assign timeout_taken = timeout_hit &&
                           (((state_q == WAIT_BUSY) && !sq_busy_i) ||
                            ((state_q == WAIT_DONE) &&  sq_busy_i));

    always_comb begin
        wdog_d = '0;
        err_d  = timeout_taken;
        if (in_wait && (state_d == state_q)) begin
            wdog_d = wdog_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end

    assign err_o = err_q;
`else
    logic unused_cfg;

    assign unused_cfg    = (TIMEOUT > 0);
    assign timeout_taken = 1'b0;
    assign err_o         = 1'b0;
`endif

    assign gnt_o       = (state_q == ISSUE) ? (NREQ'(1) << w_q) : '0;
    assign rsp_valid_o = (state_q == RESP)  ? (NREQ'(1) << w_q) : '0;
    assign busy_o      = (state_q != IDLE);
    assign sq_start_o  = (state_q == ISSUE);
    assign sq_x_bo     = x_q;
    assign y_bo        = y_q;

endmodule

// File: tb/tb_sqrt_arbiter.sv
// tb/tb_sqrt_arbiter.sv - self-checking bench for sqrt_arbiter with a behavioural sqrt unit
module tb_sqrt_arbiter;
    localparam int NREQ = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req;
    logic [17*NREQ-1:0]   x_b;
    logic [NREQ-1:0]      gnt, rsp;
    logic [7:0]           y;
    logic                 err, busy, sq_start;
    logic [16:0]          sq_x;
    logic                 sq_busy = 1'b0;
    logic [7:0]           sq_y = 8'd0;
    logic [16:0]          sq_op = '0;

    int errors = 0;
    int checks = 0;
    int gnt_count = 0;
    int rsp_count = 0;
    int sq_lat = 3;
    int sq_cnt = 0;
    bit sq_stuck = 1'b0;
    int m_last;
    int ops [NREQ];

    sqrt_arbiter #(.NREQ(NREQ), .TIMEOUT(64)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req),
        .x_bi        (x_b),
        .gnt_o       (gnt),
        .rsp_valid_o (rsp),
        .y_bo        (y),
        .err_o       (err),
        .busy_o      (busy),
        .sq_start_o  (sq_start),
        .sq_x_bo     (sq_x),
        .sq_busy_i   (sq_busy),
        .sq_y_bi     (sq_y)
    );

    function automatic int isqrt(input int v);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    function automatic int rr_pick(input int last, input logic [NREQ-1:0] m);
        for (int k = 1; k <= NREQ; k++)
            if (m[(last + k) % NREQ]) return (last + k) % NREQ;
        return -1;
    endfunction

    // Sqrt unit: busy for sq_lat cycles after start, result valid as busy falls.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sq_busy <= 1'b0;
            sq_cnt  <= 0;
            sq_y    <= 8'd0;
        end else if (sq_start && !sq_busy && !sq_stuck) begin
            sq_busy <= 1'b1;
            sq_cnt  <= sq_lat;
            sq_op   <= sq_x;
        end else if (sq_busy) begin
            if (sq_cnt <= 1) begin
                sq_busy <= 1'b0;
                sq_y    <= 8'(isqrt(int'(sq_op)));
            end
            sq_cnt <= sq_cnt - 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (gnt !== '0) gnt_count++;
        if (rsp !== '0) rsp_count++;
        if (rst_n) begin
            chk("gnt_onehot0", 32'($onehot0(gnt)), 1);
            chk("rsp_onehot0", 32'($onehot0(rsp)), 1);
            chk("gnt_rsp_excl", 32'((gnt !== '0) && (rsp !== '0)), 0);
            chk("start_with_gnt", 32'(sq_start), 32'(gnt !== '0));
        end
    end

    task automatic set_op(input int k, input int v);
        x_b[k*17 +: 17] = 17'(v);
        ops[k] = v;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        m_last = NREQ - 1;
    endtask

    task automatic await_gnt(input int w, input int exp_x, output bit ok);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (gnt === '0 && n < 300);
        ok = (gnt !== '0);
        chk("gnt_seen", 32'(ok), 1);
        if (ok) begin
            chk("gnt_winner", 32'(gnt), 1 << w);
            chk("sq_x", 32'(sq_x), exp_x);
        end
    endtask

    task automatic run_txn(input int w, input int exp_x, input int exp_y,
                           input bit exp_err, input logic [NREQ-1:0] clr);
        int n;
        bit ok;
        await_gnt(w, exp_x, ok);
        req = req & ~clr;
        if (!ok) return;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (rsp === '0 && n < 300);
        chk("rsp_seen", 32'(rsp !== '0), 1);
        if (rsp === '0) return;
        chk("rsp_winner", 32'(rsp), 1 << w);
        chk("y", 32'(y), exp_y);
        chk("err", 32'(err), 32'(exp_err));
        @(posedge clk); #1;
        chk("rsp_pulse", 32'(rsp), 0);
        chk("y_hold", 32'(y), exp_y);
        chk("err_pulse", 32'(err), 0);
    endtask

    initial begin
        int g0, r0, w;
        bit ok;
        logic [NREQ-1:0] m;

        req = '0;
        x_b = '0;
        for (int k = 0; k < NREQ; k++) ops[k] = 0;
        #1;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_rsp", 32'(rsp), 0);
        chk("rst_y", 32'(y), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_start", 32'(sq_start), 0);
        chk("rst_sq_x", 32'(sq_x), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        m_last = NREQ - 1;

        set_op(0, 144);
        req = 4'b0001;
        run_txn(0, 144, 12, 1'b0, 4'b0001);

        do_reset();
        set_op(0, 0); set_op(1, 1); set_op(2, 65535); set_op(3, 100000);
        g0 = gnt_count;
        req = 4'b1111;
        run_txn(0, 0, 0, 1'b0, 4'b0000);
        run_txn(1, 1, 1, 1'b0, 4'b0000);
        run_txn(2, 65535, 255, 1'b0, 4'b0000);
        run_txn(3, 100000, 60, 1'b0, 4'b1111);
        repeat (5) @(posedge clk); #1;
        chk("grant_total", gnt_count - g0, 4);

        do_reset();
        set_op(1, 81);
        req = 4'b0010;
        run_txn(1, 81, 9, 1'b0, 4'b0010);
        set_op(0, 25); set_op(3, 36);
        req = 4'b1001;
        run_txn(3, 36, 6, 1'b0, 4'b1000);
        run_txn(0, 25, 5, 1'b0, 4'b0001);

        sq_lat = 20;
        set_op(0, 400);
        req = 4'b0001;
        await_gnt(0, 400, ok);
        req = '0;
        repeat (6) @(posedge clk);
        #2;
        chk("pre_abort_busy", 32'(busy), 1);
        r0 = rsp_count;
        rst_n = 1'b0;
        #1;
        chk("abort_gnt", 32'(gnt), 0);
        chk("abort_rsp", 32'(rsp), 0);
        chk("abort_y", 32'(y), 0);
        chk("abort_err", 32'(err), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_start", 32'(sq_start), 0);
        chk("abort_sq_x", 32'(sq_x), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        m_last = NREQ - 1;
        repeat (30) @(posedge clk); #1;
        chk("no_rsp_after_abort", rsp_count - r0, 0);
        sq_lat = 3;
        set_op(0, 49);
        req = 4'b0001;
        run_txn(0, 49, 7, 1'b0, 4'b0001);
        m_last = 0;

        for (int t = 0; t < 24; t++) begin
            m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int k = 0; k < NREQ; k++) set_op(k, int'($urandom_range(0, 131071)));
            sq_lat = int'($urandom_range(1, 6));
            w = rr_pick(m_last, m);
            req = m;
            run_txn(w, ops[w], isqrt(ops[w]) & 255, 1'b0, '1);
            m_last = w;
        end

`ifdef SQRT_ARB_TIMEOUT_EN
        sq_stuck = 1'b1;
        set_op(2, 1000);
        req = 4'b0100;
        run_txn(2, 1000, 0, 1'b1, 4'b0100);
        sq_stuck = 1'b0;
`else
        sq_stuck = 1'b1;
        set_op(2, 1000);
        req = 4'b0100;
        r0 = rsp_count;
        await_gnt(2, 1000, ok);
        req = '0;
        repeat (100) @(posedge clk); #1;
        chk("stuck_busy", 32'(busy), 1);
        chk("stuck_no_rsp", rsp_count - r0, 0);
        do_reset();
        sq_stuck = 1'b0;
`endif

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
